nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that drives the team's 4-bit carry select adder (csa) one nibble per clock, least-significant nibble first. A registered carry links successive nibbles. Operands are captured on a start/busy/done handshake. The block sits directly upstream of csa and is the sequencing wrapper for wide additions built from the 4-bit stage.

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_csa.sv | 24 ++
 rtl/nibble_serial_adder.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants and state encoding for the nibble-serial adder
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble adder still needs one counter bit.
    function automatic int idx_width(input int nibs);
        return (nibs > 1) ? $clog2(nibs) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// rtl/nibble_serial_adder_csa.sv - 4-bit carry select adder stage
module nibble_serial_adder_csa
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Upper pair is precomputed for both incoming carries; the low pair's carry picks one.
    assign lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign hi0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1  = hi0 + 3'd1;

    assign s    = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
    assign cout = lo[2] ? hi1[2] : hi0[2];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder sequencing one csa stage per nibble
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_s;
    logic             nib_c;
    logic             accept;
    logic             last;

    assign last = (idx == LAST_IDX);

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < NIBS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib_a = opa[k*NIB_W +: NIB_W];
                nib_b = opb[k*NIB_W +: NIB_W];
            end
        end
    end

    // Only the current nibble of sum is replaced; the rest keeps partial/stale data.
    always_comb begin
        sum_nx = sum;
        for (int k = 0; k < NIBS; k++) begin
            if (idx == IDX_W'(k)) begin
                sum_nx[k*NIB_W +: NIB_W] = nib_s;
            end
        end
    end

    nibble_serial_adder_csa u_csa (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opa   <= a;
                opb   <= b;
                carry <= cin;
                idx   <= '0;
            end else if (state == RUN) begin
                sum   <= sum_nx;
                carry <= nib_c;
                if (last) begin
                    cout <= nib_c;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4)
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;

    int compared;
    int mismatched;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called on the sample right after an accepting edge; counts edges until done.
    task automatic wait_done16(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!done16 && n < 40) begin
            if (busy16) nb++;
            step();
            n++;
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input string tag, input bit scramble);
        logic [16:0] expv;
        int n;
        int nb;
        expv    = {1'b0, a} + {1'b0, b} + {16'd0, c};
        a16     = a;
        b16     = b;
        cin16   = c;
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        if (scramble) begin
            a16   = 16'hAAAA;
            b16   = 16'($urandom);
            cin16 = ~c;
        end
        wait_done16(n, nb);
        chk({tag, " latency"}, n, 4);
        chk({tag, " busy cycles"}, nb, 4);
        chk({tag, " busy at done"}, {31'd0, busy16}, 0);
        chk({tag, " result"}, {15'd0, cout16, sum16}, {15'd0, expv});
        step();
        chk({tag, " single pulse"}, {31'd0, done16}, 0);
    endtask

    initial begin
        int n;
        int nb;
        compared   = 0;
        mismatched = 0;
        rst     = 1'b1;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
        #2;
        chk("reset busy16", {31'd0, busy16}, 0);
        chk("reset done16", {31'd0, done16}, 0);
        chk("reset result16", {15'd0, cout16, sum16}, 0);
        chk("reset busy4", {31'd0, busy4}, 0);
        chk("reset done4", {31'd0, done4}, 0);
        chk("reset result4", {27'd0, cout4, sum4}, 0);
        step();
        step();
        rst = 1'b0;
        step();

        op16(16'h0000, 16'h0000, 1'b0, "zero", 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0, "ripple", 1'b0);
        op16(16'h1234, 16'h4321, 1'b1, "operand hold", 1'b1);
        chk("operand hold literal", {15'd0, cout16, sum16}, 32'h0_5556);

        // start held high through RUN: only the DONE-cycle edge may accept
        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; start16 = 1'b1;
        step();
        a16 = 16'h7FFF; b16 = 16'h0000; cin16 = 1'b1;
        wait_done16(n, nb);
        chk("b2b first latency", n, 4);
        chk("b2b first result", {15'd0, cout16, sum16}, 32'h1_0000);
        step();
        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0;
        wait_done16(n, nb);
        chk("b2b second latency", n, 4);
        chk("b2b second result", {15'd0, cout16, sum16}, 32'h0_8000);
        start16 = 1'b0;
        step();
        step();
        chk("b2b idle done", {31'd0, done16}, 0);
        chk("b2b idle busy", {31'd0, busy16}, 0);

        // asynchronous reset while nibble 2 is in flight
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
        step();
        start16 = 1'b0;
        step();
        step();
        chk("partial low byte", {24'd0, sum16[7:0]}, 32'h33);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, busy16}, 0);
        chk("async rst done", {31'd0, done16}, 0);
        chk("async rst result", {15'd0, cout16, sum16}, 0);
        step();
        chk("rst hold done", {31'd0, done16}, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no done after abandon", {31'd0, done16}, 0);
        end
        op16(16'hBEEF, 16'h4111, 1'b1, "after reset", 1'b0);

        for (int i = 0; i < 25; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "random", 1'b1);
        end

        // exhaustive WIDTH=4: done one cycle after each accepting edge
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    a4 = ~a4; b4 = 4'($urandom);
                    chk("w4 busy", {31'd0, busy4}, 1);
                    step();
                    chk("w4 done", {31'd0, done4}, 1);
                    chk("w4 result", {27'd0, cout4, sum4}, 32'(ia + ib + ic));
                end
            end
        end
        step();
        chk("w4 idle done", {31'd0, done4}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
